// File: rtl/byte_out_seq.sv
// byte_out_seq -- timed byte sequencer fed from a small command FIFO.
//
// Each command {s_data, s_dur} is queued. The sequencer presents s_data on
// dout for max(s_dur,1) clock cycles, then moves on to the next queued
// command with no gap. If the queue is empty or en is low when an entry
// finishes, it returns to IDLE and pulses done.
//
// Parameters
//   FIFO_DEPTH : command FIFO entries (power of two, >= 2)
//   DUR_W      : width of the hold-duration field
//
// Ports
//   clk     in   sole clock, rising edge
//   rstn    in   asynchronous active-low reset
//   clr     in   synchronous flush of FIFO and sequencer (highest priority)
//   en      in   allows new entries to be popped
//   s_valid in   command valid
//   s_ready out  command accept (not full; low during and right after reset)
//   s_data  in   byte to present on dout
//   s_dur   in   hold time in clk cycles (0 is treated as 1)
//   dout    out  registered parallel output byte
//   busy    out  high while an entry is being held
//   done    out  one-cycle pulse when a sequence drains
//   level   out  FIFO occupancy, 0..FIFO_DEPTH
//
// Build option
//   BYTE_OUT_SEQ_IDLE_CLR_EN : when defined, dout returns to 0 on the edge
//   that leaves HOLD for IDLE; otherwise the last byte is held through IDLE.

module byte_out_seq #(
  parameter int FIFO_DEPTH = 4,
  parameter int DUR_W      = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          clr,
  input  logic                          en,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [7:0]                    s_data,
  input  logic [DUR_W-1:0]              s_dur,
  output logic [7:0]                    dout,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int WW = 8 + DUR_W;

  generate
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("byte_out_seq: FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------
  logic [WW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] rd_addr;
  logic [LW-1:0] level_reg;
  logic [LW-1:0] level_after_pop;
  logic [LW-1:0] level_next;
  logic [WW-1:0] head_reg;
  logic          head_valid_reg;
  logic          rdy_reg;
  logic          full;
  logic          push;
  logic          pop;
  logic          pop_eff;

  assign full    = (level_reg == LW'(FIFO_DEPTH));
  // rdy_reg keeps s_ready low while in reset and until the first edge after.
  assign s_ready = rdy_reg & ~full;
  assign push    = s_valid & s_ready & ~clr;
  assign pop_eff = pop & ~clr;

  // The head register is a registered read of the entry that will be at the
  // front after this edge, so a pop can use it with no extra cycle.
  assign rd_addr         = pop_eff ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
  assign level_after_pop = level_reg - LW'(pop_eff);
  assign level_next      = level_after_pop + LW'(push);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      level_reg      <= '0;
      head_valid_reg <= 1'b0;
      rdy_reg        <= 1'b0;
    end else begin
      rdy_reg <= 1'b1;
      if (clr) begin
        wr_ptr_reg     <= '0;
        rd_ptr_reg     <= '0;
        level_reg      <= '0;
        head_valid_reg <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
        end
        rd_ptr_reg <= rd_addr;
        level_reg  <= level_next;
        // The head is only valid if the entry at rd_addr was written before
        // this edge; an entry written on this very edge is read next cycle.
        head_valid_reg <= (level_after_pop != '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {s_data, s_dur};
    end
    head_reg <= mem[rd_addr];
  end

  logic [7:0]       head_data;
  logic [DUR_W-1:0] head_dur;
  assign head_data = head_reg[WW-1:DUR_W];
  assign head_dur  = head_reg[DUR_W-1:0];

  // ---------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [DUR_W-1:0] cnt_reg, cnt_next;
  logic [7:0]       dout_reg, dout_next;
  logic             done_reg, done_next;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    dout_next  = dout_reg;
    done_next  = 1'b0;
    pop        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (en && head_valid_reg) begin
          pop        = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (cnt_reg == DUR_W'(1)) begin
          if (en && head_valid_reg) begin
            pop = 1'b1;
          end else begin
            state_next = IDLE;
            cnt_next   = '0;
            done_next  = 1'b1;
`ifdef BYTE_OUT_SEQ_IDLE_CLR_EN
            dout_next  = 8'h00;
`endif
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (pop) begin
      dout_next = head_data;
      cnt_next  = (head_dur == '0) ? DUR_W'(1) : head_dur;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      dout_reg  <= 8'h00;
      done_reg  <= 1'b0;
    end else if (clr) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      dout_reg  <= 8'h00;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      dout_reg  <= dout_next;
      done_reg  <= done_next;
    end
  end

  assign dout  = dout_reg;
  assign busy  = (state_reg == HOLD);
  assign done  = done_reg;
  assign level = level_reg;

endmodule
